// File: rtl/modexp_pkg.sv
// Shared definitions for the modular exponentiation controller.
// Holds the fixed prime modulus, default widths and the sequencer state encoding.
// Imported by modexp_ctrl; modmul takes the modulus on a port.
package modexp_pkg;

  localparam int DEF_WIDTH     = 24;
  localparam int DEF_EXP_WIDTH = 24;

  // Prime modulus 2^24 - 3; modmul's folding reduction depends on this form.
  localparam logic [23:0] MODULUS = 24'hFFFFFD;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SQR  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/modmul.sv
// Combinational 24-bit modular multiplier: p = a*b mod m, where m = 2^24 - 3.
// Ports: reset/clk (present for interface uniformity, unused), a/b operands (any 24-bit value),
//        m modulus, p result (always < m).
module modmul (
  input  logic        reset,
  input  logic        clk,
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic [23:0] m,
  output logic [23:0] p
);

  logic [47:0] prod;
  logic [25:0] fold1;
  logic [24:0] fold2;
  logic        unused_ok;

  assign unused_ok = ^{reset, clk};

  assign prod = {24'd0, a} * {24'd0, b};

  // Because 2^24 == 3 (mod m), hi*2^24 + lo folds to 3*hi + lo.
  // First fold leaves a 26-bit value; the second leaves at most 2^24 + 8.
  assign fold1 = {2'b00, prod[23:0]} + {2'b00, prod[47:24]} + {1'b0, prod[47:24], 1'b0};
  assign fold2 = {1'b0, fold1[23:0]} + {23'd0, fold1[25:24]} + {22'd0, fold1[25:24], 1'b0};

  // fold2 < 2m, so one conditional subtraction completes the reduction.
  always_comb begin
    p = fold2[23:0];
    if (fold2 >= {1'b0, m}) begin
      p = 24'(fold2 - {1'b0, m});
    end
  end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod 0xFFFFFD over one shared modmul.
// Ports: clk, reset (async active-high), start/base/exp request (sampled in IDLE),
//        busy (state != IDLE), done (one-cycle pulse), result (held until the next accepted start).
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  state_e               state_q;
  logic [WIDTH-1:0]     base_in_q;  // raw base captured with start
  logic [WIDTH-1:0]     base_q;     // base reduced mod M
  logic [WIDTH-1:0]     acc_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic                 done_q;
  logic [WIDTH-1:0]     result_q;

  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [WIDTH-1:0]     mul_p;

  assign idx_d = idx_q - IDX_W'(1);

  // Operand mux for the single shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      LOAD: begin
        mul_a = base_in_q;
        mul_b = WIDTH'(1);     // x*1 mod M reduces a base >= M
      end
      SQR: begin
        mul_a = acc_q;
        mul_b = acc_q;
      end
      MUL: begin
        mul_a = acc_q;
        mul_b = base_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  modmul u_modmul (
    .reset (reset),
    .clk   (clk),
    .a     (mul_a),
    .b     (mul_b),
    .m     (MODULUS),
    .p     (mul_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      base_in_q <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      exp_q     <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_in_q <= base;
            exp_q     <= exp;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          base_q  <= mul_p;
          acc_q   <= WIDTH'(1);
          idx_q   <= IDX_W'(EXP_WIDTH - 1);
          state_q <= SQR;
        end
        SQR: begin
          acc_q <= mul_p;
          // idx only moves after the multiply step when the bit is set.
          if (exp_q[idx_q]) begin
            state_q <= MUL;
          end else if (idx_q == '0) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= mul_p;
          end else begin
            idx_q <= idx_d;
          end
        end
        MUL: begin
          acc_q <= mul_p;
          if (idx_q == '0) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= mul_p;
          end else begin
            idx_q   <= idx_d;
            state_q <= SQR;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
